// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch front end with a DEPTH-entry prefetch queue. It issues
// sequential 4-byte fetches to an in-order, variable-latency instruction
// memory, buffers the returned words together with their PCs and presents
// the oldest one to the IF->RF stage. A taken branch resolved in RF
// redirects the fetch stream. The redirect clears the queue, and every
// response still in flight for the old stream is discarded when it arrives.
//
// Parameters
//   DEPTH     queue entries and maximum outstanding requests (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous reset, active low
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out  64  fetch byte address
//   imem_req_ready  in   1   memory accepts the request this cycle
//   imem_rsp_valid  in   1   response valid (responses return in request order)
//   imem_rsp_instr  in   32  response instruction word
//   br_taken        in   1   redirect strobe from RF
//   br_taken_pc     in   64  redirect target
//   stall           in   1   downstream hold; the head is not consumed
//   instr_valid     out  1   queue head valid
//   instr           out  32  head instruction, 0 when the queue is empty
//   pc              out  64  head PC, 0 when the queue is empty
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    input  logic        br_taken,
    input  logic [63:0] br_taken_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] pc
);

    localparam int PTR_W = $clog2(DEPTH);
    // Counters have to hold the value DEPTH itself, so one bit wider than a pointer.
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,   // normal sequential issue
        S_DRAIN = 1'b1    // waiting for stale responses after a redirect
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic               start_q;    // low for the first cycle after reset release
    logic [63:0]        fetch_pc_q, fetch_pc_d;
    logic [63:0]        rsp_pc_q,   rsp_pc_d;   // PC of the next response to be kept
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;    // valid entries in the queue
    logic [CNT_W-1:0]   out_q,      out_d;      // requests accepted, response not yet seen
    logic [CNT_W-1:0]   drop_q,     drop_d;     // responses still to be discarded

    // Queue storage. It is never reset; the occupancy count alone decides
    // whether an entry is meaningful.
    logic [31:0]        instr_mem_q [DEPTH];
    logic [63:0]        pc_mem_q    [DEPTH];

    // -----------------------------------------------------------------------
    // Per-cycle events
    // -----------------------------------------------------------------------
    logic [CNT_W:0]     occupancy;
    logic               xfer;       // request handshake this cycle
    logic               rsp_acc;    // response that belongs to an outstanding request
    logic               push;
    logic               pop;

    // Every outstanding request already owns a queue slot, so the sum of
    // queued and in-flight words decides issue and overflow is impossible.
    assign occupancy = {1'b0, count_q} + {1'b0, out_q};

    always_comb begin
        imem_req_valid = 1'b0;
        if (start_q && (state_q == S_FETCH) && !br_taken && (occupancy < DEPTH_OCC)) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign xfer          = imem_req_valid && imem_req_ready;
    // A response that arrives with nothing outstanding is spurious and ignored.
    assign rsp_acc       = imem_rsp_valid && (out_q != CNT_ZERO);

    assign instr_valid   = (count_q != CNT_ZERO);
    assign instr         = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pc            = instr_valid ? pc_mem_q[rd_ptr_q]    : 64'h0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        push       = 1'b0;
        pop        = 1'b0;

        // In-flight bookkeeping is the same with or without a redirect.
        if (xfer && !rsp_acc) begin
            out_d = out_q + CNT_ONE;
        end else if (!xfer && rsp_acc) begin
            out_d = out_q - CNT_ONE;
        end

        if (br_taken) begin
            // Redirect: everything queued or still in flight is the old stream.
            // The response arriving right now (if any) is already subtracted
            // from out_d, which discards it; whatever remains must be dropped.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = br_taken_pc;
            rsp_pc_d   = br_taken_pc;
            drop_d     = out_d;
            state_d    = (out_d != CNT_ZERO) ? S_DRAIN : S_FETCH;
        end else begin
            pop = instr_valid && !stall;

            if (rsp_acc) begin
                if (drop_q != CNT_ZERO) begin
                    drop_d = drop_q - CNT_ONE;
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 64'd4;
                end
            end

            if (xfer) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push && pop) begin
                count_d = count_q - CNT_ONE;
            end

            // Leave DRAIN on the edge where the last stale response is dropped;
            // issue resumes in the following cycle.
            if ((state_q == S_DRAIN) && (drop_d == CNT_ZERO)) begin
                state_d = S_FETCH;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            start_q    <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rsp_instr;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule
